// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin write-port arbiter with burst locking for a synchronous FIFO; FIFO_ARB_STATS_EN adds per-requester grant counters
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            fifo_w_en,
    output logic [DATA_WIDTH-1:0]           fifo_data_in,
    input  logic                            fifo_full,
    output logic                            fifo_rst_n,
    output logic                            busy,
`ifdef FIFO_ARB_STATS_EN
    output logic [$clog2(NUM_REQ)-1:0]      owner_id,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    grant_cnt
`else
    output logic [$clog2(NUM_REQ)-1:0]      owner_id
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
    localparam logic [BW-1:0] MB = BW'(MAX_BURST);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        r_state, w_state_n;
    logic [IW-1:0] r_ptr, w_ptr_n, r_owner, w_owner_n, w_start, w_win;
    logic [BW-1:0] r_cnt, w_cnt_n;
    logic [IW:0]   w_j;
    logic          w_found, w_keep;

    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] x);
        return (x == IW'(NUM_REQ - 1)) ? '0 : x + IW'(1);
    endfunction

    assign w_keep     = (r_state == BURST) && req[r_owner];
    assign w_start    = (r_state == BURST) ? f_inc(r_owner) : r_ptr;
    assign fifo_w_en  = |gnt;
    assign fifo_rst_n = ~rst;
    assign busy       = (r_state == BURST);
    assign owner_id   = r_owner;

    // round-robin search: first requester at or after w_start, wrapping modulo NUM_REQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = {1'b0, w_start} + (IW+1)'(k);
            if (w_j >= NR) w_j = w_j - NR;
            if (req[w_j[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_j[IW-1:0];
            end
        end
    end

    // one-hot grant: the burst owner has priority, nothing is granted into a full FIFO or during reset
    always_comb begin
        gnt = '0;
        if (!rst && !fifo_full) begin
            if (w_keep) gnt[r_owner] = 1'b1;
            else if (w_found) gnt[w_win] = 1'b1;
        end
    end

    // write data follows the granted requester, zero when idle
    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // next state: count owner writes, rotate on burst end or release, freeze while full
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_owner_n = r_owner;
        w_cnt_n   = r_cnt;
        if (!fifo_full) begin
            if (w_keep) begin
                w_cnt_n = r_cnt + BW'(1);
                if (w_cnt_n == MB) begin
                    w_state_n = IDLE;
                    w_ptr_n   = f_inc(r_owner);
                    w_cnt_n   = '0;
                end
            end else if (w_found) begin
                w_owner_n = w_win;
                if (MAX_BURST > 1) begin
                    w_state_n = BURST;
                    w_cnt_n   = BW'(1);
                end else begin
                    w_state_n = IDLE;
                    w_ptr_n   = f_inc(w_win);
                    w_cnt_n   = '0;
                end
            end else if (r_state == BURST) begin
                w_state_n = IDLE;
                w_ptr_n   = f_inc(r_owner);
                w_cnt_n   = '0;
            end
        end
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_owner <= w_owner_n;
            r_cnt   <= w_cnt_n;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // saturating per-requester count of accepted words
    always_ff @(posedge clk) begin
        if (rst) grant_cnt <= '0;
        else
            for (int i = 0; i < NUM_REQ; i++)
                if (gnt[i] && grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] != '1)
                    grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
    end
`endif
endmodule
